// File: rtl/featuremap_accum.sv
`default_nettype none
// ============================================================================
// Module   : featuremap_accum
// Purpose  : Merges the per-input-channel conv2d5x5 partial results of one
//            output feature map into a single stream. Channel results that
//            arrive with different skew are captured and aligned, then summed
//            together with BIAS in a pipelined adder tree. The result is
//            saturated to DATA_WIDTH.
// Revision : 1.0 - initial parametrised release
// ----------------------------------------------------------------------------
// Parameters:
//   DATA_WIDTH - signed width of each channel input and of data_out
//   FRAC_BITS  - fractional bits (meaningful only for BIAS; arithmetic is int)
//   NUM_CH     - number of input channels (>= 1)
//   BIAS       - signed bias added to every sum, same Q format as the inputs
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   data_in   in   NUM_CH*DATA_WIDTH, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   valid_in  in   NUM_CH, bit k qualifies channel k for one cycle
//   data_out  out  DATA_WIDTH saturated sum (holds when valid_out=0)
//   valid_out out  one-cycle strobe per completed channel set
//   overrun   out  sticky: a channel re-sent before its set was launched
// Latency  : clog2(NUM_CH+1)+2 cycles from the last captured channel.
// Options  : define FEATUREMAP_ACCUM_RELU_EN to clamp negative results to 0.
// ============================================================================
module featuremap_accum #(
    parameter int                     DATA_WIDTH = 24,
    parameter int                     FRAC_BITS  = 16,
    parameter int                     NUM_CH     = 6,
    parameter logic [DATA_WIDTH-1:0]  BIAS       = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
    input  logic [NUM_CH-1:0]            valid_in,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         valid_out,
    output logic                         overrun
);

    // Number of tree nodes at a given level (level 0 = the NUM_CH+1 leaves).
    function automatic int node_cnt(input int lvl);
        int n;
        n = NUM_CH + 1;
        for (int i = 0; i < lvl; i++) n = (n + 1) / 2;
        return n;
    endfunction

    // Offset of a level's first node in the flattened node array.
    function automatic int node_off(input int lvl);
        int o;
        o = 0;
        for (int i = 0; i < lvl; i++) o = o + node_cnt(i);
        return o;
    endfunction

    localparam int c_levels = $clog2(NUM_CH + 1);
    localparam int ACC_W    = DATA_WIDTH + c_levels;
    localparam int c_ext    = ACC_W - DATA_WIDTH;
    localparam int c_total  = node_off(c_levels + 1);

    localparam logic signed [ACC_W-1:0] c_sat_max =
        {{(c_ext + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_sat_min =
        {{(c_ext + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    generate
        if (NUM_CH < 1 || FRAC_BITS < 0 || FRAC_BITS >= DATA_WIDTH) begin : g_param_check
            $error("featuremap_accum: illegal NUM_CH or FRAC_BITS");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Capture / alignment
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]       r_hold [NUM_CH];
    logic [NUM_CH-1:0]           r_flag;
    logic                        r_overrun;
    logic                        w_launch;
    logic [NUM_CH-1:0]           w_ovr;

    assign w_launch = &r_flag;
    // A repeat valid only counts as overrun when the held value cannot be
    // consumed this cycle; in a launch cycle it simply starts the next set.
    assign w_ovr    = valid_in & r_flag & {NUM_CH{~w_launch}};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flag    <= '0;
            r_hold    <= '{default: '0};
            r_overrun <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                // Set wins over the launch clear so full-rate streaming works.
                if (valid_in[k] && (!r_flag[k] || w_launch)) begin
                    r_hold[k] <= data_in[k*DATA_WIDTH +: DATA_WIDTH];
                    r_flag[k] <= 1'b1;
                end else if (w_launch) begin
                    r_flag[k] <= 1'b0;
                end
            end
            if (|w_ovr) r_overrun <= 1'b1;
        end
    end

    assign overrun = r_overrun;

    // ------------------------------------------------------------------
    // Adder tree: all levels flattened into one array. Level 0 holds the
    // sign-extended leaves; each further level pairs the previous one, with
    // an odd last node registered straight through to keep stages aligned.
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0] r_node [c_total];
    logic [c_levels:0]       r_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_node <= '{default: '0};
            r_vld  <= '0;
        end else begin
            r_vld <= {r_vld[c_levels-1:0], w_launch};
            if (w_launch) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    r_node[k] <= {{c_ext{r_hold[k][DATA_WIDTH-1]}}, r_hold[k]};
                end
                r_node[NUM_CH] <= {{c_ext{BIAS[DATA_WIDTH-1]}}, BIAS};
            end
            for (int l = 1; l <= c_levels; l++) begin
                for (int n = 0; n < node_cnt(l); n++) begin
                    if (2 * n + 1 < node_cnt(l - 1)) begin
                        r_node[node_off(l) + n] <= r_node[node_off(l - 1) + 2 * n]
                                                 + r_node[node_off(l - 1) + 2 * n + 1];
                    end else begin
                        r_node[node_off(l) + n] <= r_node[node_off(l - 1) + 2 * n];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output stage: saturate (and optionally rectify), then register
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0] w_sum;
    logic [DATA_WIDTH-1:0]   w_sat;
    logic [DATA_WIDTH-1:0]   w_res;

    assign w_sum = r_node[c_total-1];

    always_comb begin
        w_sat = w_sum[DATA_WIDTH-1:0];
        if (w_sum > c_sat_max) begin
            w_sat = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
        end else if (w_sum < c_sat_min) begin
            w_sat = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
        end
    end

`ifdef FEATUREMAP_ACCUM_RELU_EN
    assign w_res = w_sat[DATA_WIDTH-1] ? '0 : w_sat;
`else
    assign w_res = w_sat;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= r_vld[c_levels];
            if (r_vld[c_levels]) data_out <= w_res;
        end
    end

endmodule
`default_nettype wire

// File: doc/featuremap_accum.md
Name: featuremap_accum

Overview:
- Parametrised successor to the fixed six-instance feature-map wrapper. Merges the per-input-channel conv2d5x5 partial results for one output feature map into a single stream.
- Aligns channel results that arrive with different skew, then sums them with a bias in a pipelined adder tree. The result is saturated to DATA_WIDTH.
- Sits between the NUM_CH conv2d5x5 instances of a conv layer and the following pooling stage.

Parameters:
- DATA_WIDTH, 24: signed two's-complement fixed-point width of each channel input and of data_out.
- FRAC_BITS, 16: fractional bits. Applies only to the BIAS interpretation; the arithmetic is plain integer.
- NUM_CH, 6: number of input channels; must be at least 1.
- BIAS, 0: signed DATA_WIDTH-bit bias added to every sum, in the same Q format as the inputs.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- data_in  input  NUM_CH*DATA_WIDTH  channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- valid_in  input  NUM_CH  bit k qualifies channel k for one cycle.
- data_out  output  DATA_WIDTH  saturated sum.
- valid_out  output  1  one-cycle strobe qualifying data_out.
- overrun  output  1  sticky error flag.

Behaviour:
- Reset values: data_out=0, valid_out=0, overrun=0. All capture flags, holding registers and tree pipeline valids are cleared.
- Reset mid-operation discards every partial set and every in-flight tree stage. No valid_out follows a reset until new inputs complete a set.
- Capture:
  - Each channel has a holding register and a captured flag.
  - On an edge with valid_in[k]=1 and flag[k]=0, data_in slice k is stored and flag[k] is set.
- Launch:
  - In any cycle where all flags are 1, the held values and BIAS are sign-extended to ACC_W = DATA_WIDTH + clog2(NUM_CH+1) bits and loaded into tree stage 0 at the next edge.
  - All flags clear on that same edge.
- Simultaneous launch and capture: if valid_in[k]=1 in a launch cycle, the new value is captured and flag[k] ends at 1 (set wins over clear). This gives one result per cycle when all channels are valid every cycle.
- Overrun: valid_in[k]=1 while flag[k]=1 in a non-launch cycle. The new data is dropped, the held value is kept, and overrun sets and holds until rst.
- Adder tree:
  - NUM_CH+1 leaves (the channels plus the bias), pairwise, one register stage per level, clog2(NUM_CH+1) levels.
  - An odd leaf at a level passes through a register so stages stay aligned.
  - No intermediate overflow is possible at ACC_W.
- Output stage (one register):
  - Sum > 2^(DATA_WIDTH-1)-1 gives 0x7FFFFF for the default width.
  - Sum < -2^(DATA_WIDTH-1) gives 0x800000.
  - Otherwise the sum is truncated to DATA_WIDTH bits.
- Latency: LAT = clog2(NUM_CH+1)+2 cycles, counted from the edge that samples the last outstanding valid_in bit to the edge where valid_out rises. Default LAT=5.
- valid_out is high for exactly one cycle per completed set.
- data_out holds its last value when valid_out=0.
- No backpressure: downstream must accept one result per cycle.
- NUM_CH=1: the tree has 2 leaves, 1 level, so LAT=3.

Optional Feature:
- Macro: FEATUREMAP_ACCUM_RELU_EN.
- Defined: the output stage applies ReLU after saturation; any negative result gives data_out=0. valid_out timing is unchanged.
- Undefined: the signed saturated value passes through.
- Latency is identical in both builds.

Test Plan:
All values below use the defaults (Q8.16, 1.0=0x010000).
1. Aligned set: all 6 channels 0x010000 in one cycle, BIAS=0 -> exactly 5 cycles later valid_out=1 for one cycle, data_out=0x060000.
2. Skewed arrival: ch0..ch5 each 0x008000, valid on successive cycles 0..5, BIAS=0x010000 (1.0) -> single valid_out 5 cycles after the ch5 edge, data_out=0x040000; no output before that.
3. Back-to-back streaming: all channels valid for 4 consecutive cycles with values 1,2,3,4 (x0x010000) -> valid_out high on 4 consecutive cycles, data_out=0x060000, 0x0C0000, 0x120000, 0x180000; overrun stays 0.
4. Saturation: all channels 0x7FFFFF, BIAS=0 -> data_out=0x7FFFFF. All channels 0x800000 -> data_out=0x800000 without the macro, 0x000000 with FEATUREMAP_ACCUM_RELU_EN.
5. Overrun: ch0 valid twice (0x010000, then 0x050000) before ch1..ch5 (each 0x010000) arrive -> overrun=1 and sticky; result uses the first value, data_out=0x060000.
6. Reset mid-flight: rst asserted 2 cycles after a complete aligned set -> valid_out stays 0, all outputs 0. The next full set produces a correct result with latency 5.
